// File: rtl/clk_tree_test_pkg.sv
// Shared types and constants for the clock-tree test sequencer; no logic, no latency.
// Holds the FSM state encoding, the DUT mode-select codes and the signature width.
package clk_tree_test_pkg;

   localparam int SIG_W = 32;

   localparam logic [1:0] SEL_XOR  = 2'd0;
   localparam logic [1:0] SEL_AND  = 2'd1;
   localparam logic [1:0] SEL_OR   = 2'd2;
   localparam logic [1:0] SEL_ZERO = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      ASSERT_RST,
      RUN,
      FREEZE,
      SETTLE,
      CAPTURE,
      DONE
   } state_t;

   function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] v);
      return {v[SIG_W-2:0], v[SIG_W-1]};
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/clk_tree_test_sequencer_if.sv
// Control/result bundle between the sequencer (slave) and whoever starts it (master).
// Plain wires, no flow control: start is a level sampled in IDLE, results are pulses.
interface clk_tree_test_sequencer_if #(parameter int WIDTH = 20);
   import clk_tree_test_pkg::*;

   logic             start;
   logic             abort;
   logic [WIDTH-1:0] mux_in;
   logic             dut_clr_n;
   logic             dut_t;
   logic [1:0]       dut_sel;
   logic             busy;
   logic             done;
   logic             sample_valid;
   logic [1:0]       sample_sel;
   logic [WIDTH-1:0] sample_data;
   logic [SIG_W-1:0] signature;
   logic             err;

   modport master (
      output start, abort, mux_in,
      input  dut_clr_n, dut_t, dut_sel, busy, done, sample_valid,
             sample_sel, sample_data, signature, err
   );

   modport slave (
      input  start, abort, mux_in,
      output dut_clr_n, dut_t, dut_sel, busy, done, sample_valid,
             sample_sel, sample_data, signature, err
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus that is static whenever it is sampled; 2-cycle latency.
// No backpressure; async active-low reset clears both stages to 0.
module sync_2ff #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_tree_test_sequencer.sv
// Sequences a toggle-flop DUT: reset, toggle window, freeze, then capture all four sel modes.
// One run per start pulse (ignored while busy); abort returns to IDLE next cycle; no backpressure.
module clk_tree_test_sequencer
   import clk_tree_test_pkg::*;
#(
   parameter int             WIDTH         = 20,
   parameter int             RST_CYCLES    = 4,
   parameter int             RUN_CYCLES    = 16,
   parameter int             SETTLE_CYCLES = 3,
   parameter logic [SIG_W-1:0] SIG_SEED    = 32'h0
) (
   input logic                      clk,
   input logic                      clr_n,
   clk_tree_test_sequencer_if.slave bus
);

   localparam int CW = $clog2(max3(RST_CYCLES, RUN_CYCLES, SETTLE_CYCLES) + 1);
   localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] RUN_LAST    = CW'(RUN_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mux_sync;
   logic             dut_clr_n_q;
   logic             dut_t_q;
   logic [1:0]       dut_sel_q;
   logic             busy_q;
   logic             done_q;
   logic             valid_q;
   logic [1:0]       sample_sel_q;
   logic [WIDTH-1:0] sample_data_q;
   logic [SIG_W-1:0] signature_q;
   logic             err_q;

   sync_2ff #(.WIDTH(WIDTH)) u_sync (
      .clk   (clk),
      .rst_n (clr_n),
      .d     (bus.mux_in),
      .q     (mux_sync)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state         <= IDLE;
         cnt           <= '0;
         dut_clr_n_q   <= 1'b0;
         dut_t_q       <= 1'b0;
         dut_sel_q     <= SEL_XOR;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         valid_q       <= 1'b0;
         sample_sel_q  <= 2'd0;
         sample_data_q <= '0;
         signature_q   <= SIG_SEED;
         err_q         <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         if (bus.abort) begin
            // From IDLE only the DUT reset is re-asserted; sel keeps the last run's mode.
            state       <= IDLE;
            cnt         <= '0;
            busy_q      <= 1'b0;
            dut_clr_n_q <= 1'b0;
            dut_t_q     <= 1'b0;
            if (state != IDLE) dut_sel_q <= SEL_XOR;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     state       <= ASSERT_RST;
                     cnt         <= '0;
                     busy_q      <= 1'b1;
                     signature_q <= SIG_SEED;
                     err_q       <= 1'b0;
                     dut_clr_n_q <= 1'b0;
                     dut_sel_q   <= SEL_XOR;
                  end
               end
               ASSERT_RST: begin
                  if (cnt == RST_LAST) begin
                     cnt         <= '0;
                     state       <= RUN;
                     dut_clr_n_q <= 1'b1;
                     dut_t_q     <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               RUN: begin
                  if (cnt == RUN_LAST) begin
                     cnt     <= '0;
                     state   <= FREEZE;
                     dut_t_q <= 1'b0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               FREEZE: begin
                  if (cnt == SETTLE_LAST) begin
                     cnt   <= '0;
                     state <= SETTLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               SETTLE: begin
                  if (cnt == SETTLE_LAST) begin
                     cnt   <= '0;
                     state <= CAPTURE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               CAPTURE: begin
                  sample_data_q <= mux_sync;
                  sample_sel_q  <= dut_sel_q;
                  valid_q       <= 1'b1;
                  signature_q   <= rotl1(signature_q) ^ SIG_W'(mux_sync);
                  if (dut_sel_q == SEL_ZERO && mux_sync != '0) err_q <= 1'b1;
                  if (dut_sel_q != SEL_ZERO) begin
                     dut_sel_q <= dut_sel_q + 2'd1;
                     state     <= SETTLE;
                  end else begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
               DONE: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.dut_clr_n    = dut_clr_n_q;
   assign bus.dut_t        = dut_t_q;
   assign bus.dut_sel      = dut_sel_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.sample_valid = valid_q;
   assign bus.sample_sel   = sample_sel_q;
   assign bus.sample_data  = sample_data_q;
   assign bus.signature    = signature_q;
   assign bus.err          = err_q;

endmodule

// File: doc/clk_tree_test_sequencer.md
Name: clk_tree_test_sequencer

Overview:
- Single-clock controller that sequences a multi-clock-domain toggle-flop array under test (the "DUT").
- Each run: holds the DUT in reset, enables toggling for a fixed window, freezes it, then steps the 2-bit mode select through all four values. For each select value it captures the synchronised 20-bit result word.
- Folds the four captures into a rotate-XOR signature and flags a non-zero result in the forced-zero mode.
- Sits beside the DUT in the clock-tree regression designs, so a run is fully self-checking from one start pulse.

Parameters:
- WIDTH, 20, width of the DUT result bus; legal range 1..32.
- RST_CYCLES, 4, cycles that dut_clr_n is held low at run start; must be ≥1.
- RUN_CYCLES, 16, cycles that dut_t is held high; must be ≥1.
- SETTLE_CYCLES, 3, wait cycles after freeze and after each select change before capture; must be ≥2 (synchroniser depth).
- SIG_SEED, 32'h0, signature value loaded at run start.

Ports:
- clk  in  1  sequencer clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled only in IDLE
- abort  in  1  synchronous abort; any non-IDLE state returns to IDLE
- mux_in  in  WIDTH  DUT result bus; asynchronous to clk
- dut_clr_n  out  1  DUT reset, active low
- dut_t  out  1  DUT toggle enable
- dut_sel  out  2  DUT mode select
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run completion
- sample_valid  out  1  one-cycle pulse per capture
- sample_sel  out  2  dut_sel value for the current capture
- sample_data  out  WIDTH  captured, synchronised result
- signature  out  32  running signature
- err  out  1  sticky per run: the sel=3 capture was non-zero

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (clr_n). Polarity and synchronicity are fixed.
- Reset values, applied immediately while clr_n is low:
  - state = IDLE
  - dut_clr_n = 0, dut_t = 0, dut_sel = 0
  - busy, done, sample_valid, err = 0
  - sample_sel = 0, sample_data = 0
  - signature = SIG_SEED
  - synchroniser flops = 0
- States and transitions:
  - IDLE: start=1 → ASSERT_RST. On that edge: signature ← SIG_SEED, err ← 0, dut_clr_n ← 0, dut_sel ← 0.
  - ASSERT_RST: lasts RST_CYCLES cycles, then → RUN with dut_clr_n ← 1 and dut_t ← 1.
  - RUN: lasts RUN_CYCLES cycles, then → FREEZE with dut_t ← 0.
  - FREEZE: lasts SETTLE_CYCLES cycles, then → SETTLE.
  - SETTLE: lasts SETTLE_CYCLES cycles, then → CAPTURE.
  - CAPTURE (one cycle):
    - sample_data ← sync(mux_in), sample_sel ← dut_sel, sample_valid = 1 on the next cycle.
    - signature ← rotl1(signature) ^ zero-extended sample.
    - If dut_sel = 3 and sample ≠ 0, then err ← 1.
    - If dut_sel < 3: dut_sel increments and state → SETTLE. Otherwise → DONE.
  - DONE (one cycle): done = 1, then → IDLE.
- In IDLE after a completed run, dut_clr_n stays 1 and dut_sel stays 3, so the DUT state remains observable. It is re-asserted low only by the next start or by abort.
- Latency, with start seen in IDLE at cycle 0:
  - busy is high from cycle 1.
  - Captures occur at cycles 1+RST+RUN+SETTLE+k·(SETTLE+1)+SETTLE, for k = 0..3.
  - done pulses at 1+RST+RUN+SETTLE+4·(SETTLE+1). With defaults: captures at 27, 31, 35, 39; done at 40.
- mux_in passes through a 2-flop synchroniser. Multi-bit synchronisation is legal because mux_in is static during SETTLE: dut_t is 0 and dut_sel is stable.
- Boundary conditions:
  - start while busy: ignored; no queueing.
  - start and abort in the same cycle in IDLE: abort wins; stay IDLE with dut_clr_n ← 0.
  - abort in any non-IDLE state: → IDLE next cycle with dut_clr_n ← 0, dut_t ← 0, dut_sel ← 0. No done or sample_valid pulse; signature and err hold their values.
  - abort in the DONE cycle: done still pulses.
  - clr_n low mid-run: immediate return to reset values; no done pulse.
- Cycle counters are sized with $clog2 of max(RST, RUN, SETTLE)+1 and wrap only under reload control, never free-running.

Decomposition:
- Shared package clk_tree_test_pkg:
  - state enum (IDLE, ASSERT_RST, RUN, FREEZE, SETTLE, CAPTURE, DONE)
  - SEL_XOR=0, SEL_AND=1, SEL_OR=2, SEL_ZERO=3 constants
  - signature width constant 32
- One sub-module: sync_2ff, parameterised by WIDTH, with async active-low reset to 0.

Test Plan:
- Reset, then mux_in=0 and start pulse → busy high at cycle 1, dut_clr_n low for cycles 1-4, dut_t high for cycles 5-20. sample_valid pulses after cycles 27/31/35/39 with sample_sel 0,1,2,3. done pulses at cycle 40; signature=0x0, err=0.
- mux_in=20'h00001 constant → signature=0x0000000F and err=1 after done.
- DUT model responding per sel (0x12345, 0x00000, 0xFFFFF, 0x00000) → sample_data matches each value, err=0. Signature = rotl chain of these values from seed 0 (bench reference model).
- abort asserted at cycle 10 (RUN) → IDLE at cycle 11 with dut_clr_n=0, dut_t=0, busy=0, no done pulse. A new start then completes a normal run.
- start re-pulsed at cycles 5 and 30 during a run → no effect; timing is identical to the first scenario.
- clr_n pulled low at cycle 33 → all outputs take reset values asynchronously. After release, IDLE ignores a missing start; a later start gives a full, correct run.
